// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider controller.
// Optional period counter is enabled by defining CLKDIV_PERIOD_CNT_EN.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    // Ratios below MIN_DIV cannot form a period with both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        if (d < 32'(MIN_DIV)) begin
            clamp_div = 32'(MIN_DIV);
        end else begin
            clamp_div = d;
        end
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter for the divider: runs 0..div-1 and produces the registered
// divided clock (high-biased for odd ratios) plus the period-start strobe.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic             div_clk,
    output logic             div_en
);

    logic [CNT_W-1:0] cnt_r;
    logic             div_clk_r;
    logic             div_en_r;
    logic [CNT_W:0]   cnt_inc_s;
    logic [CNT_W:0]   half_s;

    // One extra bit so div = 2^CNT_W-1 does not overflow the half-period compare.
    assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign half_s    = ({1'b0, div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    assign wrap      = (cnt_inc_s == {1'b0, div});

    assign div_clk = div_clk_r;
    assign div_en  = div_en_r;

    // Counter and output registers; outputs are derived from the next count value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            div_clk_r <= 1'b0;
            div_en_r  <= 1'b0;
        end else if (load) begin
            cnt_r     <= '0;
            div_clk_r <= 1'b1;
            div_en_r  <= 1'b1;
        end else if (adv) begin
            cnt_r     <= cnt_inc_s[CNT_W-1:0];
            div_clk_r <= (cnt_inc_s < half_s);
            div_en_r  <= 1'b0;
        end else begin
            cnt_r     <= '0;
            div_clk_r <= 1'b0;
            div_en_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Divider controller: ratio handshake and STOP/RUN/PEND sequencing so that ratio
// changes and stops land on period boundaries. Macro: CLKDIV_PERIOD_CNT_EN.
module clkdiv_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             div_clk,
    output logic             div_en,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cur_div_r, cur_div_nxt_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_nxt_s;
    logic [CNT_W-1:0] cfg_div_cl_s;
    logic             cfg_ready_r;
    logic             busy_r;
    logic             hs_s;
    logic             wrap_s;
    logic             adv_s;
    logic             load_s;

    assign hs_s         = cfg_valid && cfg_ready_r;
    assign cfg_div_cl_s = CNT_W'(clamp_div(32'(cfg_div)));

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign cur_div   = cur_div_r;

    clkdiv_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv_s),
        .load    (load_s),
        .div     (cur_div_r),
        .wrap    (wrap_s),
        .div_clk (div_clk),
        .div_en  (div_en)
    );

    // Next-state, ratio update and counter command decode.
    always_comb begin
        state_nxt_s    = state_r;
        cur_div_nxt_s  = cur_div_r;
        pend_div_nxt_s = pend_div_r;
        adv_s          = 1'b0;
        load_s         = 1'b0;
        case (state_r)
            STOP: begin
                if (hs_s) begin
                    cur_div_nxt_s = cfg_div_cl_s;
                end else begin
                    cur_div_nxt_s = cur_div_r;
                end
                if (run) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            RUN: begin
                if (wrap_s && !run) begin
                    // No period follows, so a ratio accepted here takes effect directly.
                    state_nxt_s = STOP;
                    if (hs_s) begin
                        cur_div_nxt_s = cfg_div_cl_s;
                    end else begin
                        cur_div_nxt_s = cur_div_r;
                    end
                end else begin
                    load_s = wrap_s;
                    adv_s  = !wrap_s;
                    if (hs_s) begin
                        pend_div_nxt_s = cfg_div_cl_s;
                        state_nxt_s    = PEND;
                    end else begin
                        state_nxt_s    = RUN;
                    end
                end
            end
            PEND: begin
                if (wrap_s) begin
                    cur_div_nxt_s = pend_div_r;
                    if (run) begin
                        state_nxt_s = RUN;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = STOP;
                    end
                end else begin
                    adv_s       = 1'b1;
                    state_nxt_s = PEND;
                end
            end
            default: begin
                state_nxt_s = STOP;
            end
        endcase
    end

    // Controller state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= STOP;
            cur_div_r   <= CNT_W'(DEF_DIV);
            pend_div_r  <= '0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_div_r   <= cur_div_nxt_s;
            pend_div_r  <= pend_div_nxt_s;
            cfg_ready_r <= (state_nxt_s != PEND);
            busy_r      <= (state_nxt_s != STOP);
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_r;

    assign period_cnt = period_cnt_r;

    // Completed-period counter; a new ratio restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_r <= 16'd0;
        end else if (hs_s) begin
            period_cnt_r <= 16'd0;
        end else if ((state_r != STOP) && wrap_s && (period_cnt_r != 16'hFFFF)) begin
            period_cnt_r <= period_cnt_r + 16'd1;
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl: expected div_clk/div_en per cycle are
// queued from the ratio being exercised and popped one per clock.
module tb_clkdiv_ratio_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = 8'd0;
    logic             cfg_ready;
    logic             div_clk;
    logic             div_en;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int        tests = 0;
    int        fails = 0;
    logic [1:0] sb[$];
    string     phase = "reset";

    clkdiv_ratio_ctrl #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .div_clk   (div_clk),
        .div_en    (div_en),
        .busy      (busy),
        .cur_div   (cur_div)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {div_clk, div_en} for one full period of ratio n.
    task automatic push_period(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i < (n + 1) / 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic step_chk();
        logic [1:0] e;
        step();
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb_underflow: observed %0d expected >0 entries", phase, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({phase, "_wave"}, 32'({div_clk, div_en}), 32'(e));
        end
    endtask

    task automatic check_cycles(input int k);
        for (int i = 0; i < k; i++) step_chk();
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_div_clk", 32'(div_clk), 32'd0);
        chk("rst_div_en", 32'(div_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cur_div", 32'(cur_div), 32'd4);
        rst = 1'b0;

        // Default ratio 4: 1100 repeating, strobe on each period start
        phase = "def4";
        run = 1'b1;
        push_period(4); push_period(4); push_period(4);
        check_cycles(12);
        chk("def4_busy", 32'(busy), 32'd1);
        chk("def4_cur_div", 32'(cur_div), 32'd4);
`ifdef CLKDIV_PERIOD_CNT_EN
        chk("def4_period_cnt", 32'(period_cnt), 32'd2);
`endif
        run = 1'b0;
        step();
        chk("def4_stop_busy", 32'(busy), 32'd0);
        chk("def4_stop_clk", 32'(div_clk), 32'd0);

        // Odd ratio loaded in STOP
        phase = "odd5";
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        chk("odd5_cur_div", 32'(cur_div), 32'd5);
        run = 1'b1;
        push_period(5); push_period(5);
        check_cycles(10);

        // Handshake exactly on a boundary applies one period later
        phase = "bnd";
        cfg_valid = 1'b1; cfg_div = 8'd4;
        push_period(5); push_period(4); push_period(4);
        step_chk();
        cfg_valid = 1'b0;
        chk("bnd_ready_low", 32'(cfg_ready), 32'd0);
        chk("bnd_cur_div_old", 32'(cur_div), 32'd5);
        check_cycles(4);
        chk("bnd_ready_still_low", 32'(cfg_ready), 32'd0);
        check_cycles(1);
        chk("bnd_cur_div_new", 32'(cur_div), 32'd4);
        chk("bnd_ready_back", 32'(cfg_ready), 32'd1);
        check_cycles(7);

        // Mid-period change 4 -> 6 offered at cnt=1
        phase = "mid6";
        push_period(4);
        check_cycles(2);
        cfg_valid = 1'b1; cfg_div = 8'd6;
        step_chk();
        cfg_valid = 1'b0;
        chk("mid6_ready_low", 32'(cfg_ready), 32'd0);
        check_cycles(1);
        push_period(6); push_period(6);
        check_cycles(12);
        chk("mid6_cur_div", 32'(cur_div), 32'd6);
        run = 1'b0;
        step();
        chk("mid6_stop_busy", 32'(busy), 32'd0);

        // cfg_div=0 with simultaneous run rise: clamped ratio used from the first period
        phase = "clamp0";
        cfg_valid = 1'b1; cfg_div = 8'd0; run = 1'b1;
        push_period(2); push_period(2); push_period(2);
        step_chk();
        cfg_valid = 1'b0;
        chk("clamp0_cur_div", 32'(cur_div), 32'd2);
        check_cycles(5);

        // cfg_div=1 on a boundary: clamped to 2 after the pending period
        phase = "clamp1";
        cfg_valid = 1'b1; cfg_div = 8'd1;
        push_period(2); push_period(2); push_period(2);
        step_chk();
        cfg_valid = 1'b0;
        check_cycles(5);
        chk("clamp1_cur_div", 32'(cur_div), 32'd2);

        // Ratio 8, then stop requested at cnt=1: six more cycles then idle
        phase = "stop8";
        cfg_valid = 1'b1; cfg_div = 8'd8;
        push_period(2); push_period(8);
        step_chk();
        cfg_valid = 1'b0;
        check_cycles(3);
        run = 1'b0;
        check_cycles(6);
        chk("stop8_busy_before", 32'(busy), 32'd1);
        step();
        chk("stop8_div_clk", 32'(div_clk), 32'd0);
        chk("stop8_div_en", 32'(div_en), 32'd0);
        chk("stop8_busy", 32'(busy), 32'd0);
        chk("stop8_cur_div", 32'(cur_div), 32'd8);

        // run dropped while a ratio is pending: ratio still loaded, then STOP
        phase = "pendstop";
        run = 1'b1;
        push_period(8);
        check_cycles(2);
        cfg_valid = 1'b1; cfg_div = 8'd3;
        step_chk();
        cfg_valid = 1'b0;
        run = 1'b0;
        check_cycles(5);
        step();
        chk("pendstop_busy", 32'(busy), 32'd0);
        chk("pendstop_div_clk", 32'(div_clk), 32'd0);
        chk("pendstop_cur_div", 32'(cur_div), 32'd3);
        chk("pendstop_ready", 32'(cfg_ready), 32'd1);

        // Reset while PEND at cnt=2 discards the pending ratio
        phase = "rstpend";
        run = 1'b1;
        push_period(3);
        step_chk();
        cfg_valid = 1'b1; cfg_div = 8'd7;
        step_chk();
        cfg_valid = 1'b0;
        step_chk();
        chk("rstpend_ready_low", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        chk("rstpend_div_clk", 32'(div_clk), 32'd0);
        chk("rstpend_cur_div", 32'(cur_div), 32'd4);
        chk("rstpend_ready", 32'(cfg_ready), 32'd1);
        chk("rstpend_busy", 32'(busy), 32'd0);
`ifdef CLKDIV_PERIOD_CNT_EN
        chk("rstpend_period_cnt", 32'(period_cnt), 32'd0);
`endif
        run = 1'b1;
        push_period(4); push_period(4);
        check_cycles(8);
        chk("rstpend_cur_div_after", 32'(cur_div), 32'd4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
